// File: rtl/mem_access_unit.sv
// Memory-stage access controller: registered request port with byte-lane
// steering, byte load extension and two-access indirect (LDI/STI) support.
module mem_access_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic                    indirect,
    input  logic                    byte_op,
    input  logic                    sign_ext,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    hold_in,
    input  logic                    mem_resp,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    stall
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, PTR, DATA, DONE} state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rd_q;
    logic                  wr_q;
    logic                  byte_q;
    logic                  sext_q;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [7:0]            lane_byte;
    logic [LANES-1:0]      lane_hot;

    assign accept    = valid & (mem_read | mem_write);
    assign word_addr = {addr_q[ADDR_WIDTH-1:LB], {LB{1'b0}}};

    always_comb begin
        lane_byte = '0;
        lane_hot  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (addr_q[LB-1:0] == LB'(i)) begin
                lane_byte   = mem_rdata[8*i +: 8];
                lane_hot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept)   state_nx = indirect ? PTR : DATA;
            PTR:  if (mem_resp) state_nx = DATA;
            DATA: if (mem_resp) state_nx = DONE;
            DONE: if (!hold_in) state_nx = IDLE;
            default:            state_nx = IDLE;
        endcase
    end

    // A simultaneous read+write is captured as a read only.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            byte_q    <= 1'b0;
            sext_q    <= 1'b0;
            load_data <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    rd_q    <= mem_read;
                    wr_q    <= mem_write & ~mem_read;
                    byte_q  <= byte_op;
                    sext_q  <= sign_ext;
                end
                PTR: if (mem_resp) addr_q <= mem_rdata[ADDR_WIDTH-1:0];
                DATA: if (mem_resp && rd_q) begin
                    load_data <= byte_q
                        ? {{(DATA_WIDTH-8){sext_q & lane_byte[7]}}, lane_byte}
                        : mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_wmask   = '0;
        mem_address = '0;
        mem_wdata   = '0;
        stall       = 1'b0;
        unique case (state)
            IDLE: stall = accept;
            PTR: begin
                stall       = 1'b1;
                mem_read_o  = 1'b1;
                mem_address = word_addr;
            end
            DATA: begin
                stall       = 1'b1;
                mem_read_o  = rd_q;
                mem_write_o = wr_q;
                mem_address = byte_q ? addr_q : word_addr;
                if (wr_q) begin
                    mem_wmask = byte_q ? lane_hot : '1;
                    mem_wdata = byte_q ? {LANES{wdata_q[7:0]}} : wdata_q;
                end
            end
            DONE: stall = 1'b0;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level expectations
// checked every cycle on a 16-bit instance, plus literal checks on a 32-bit one.
module tb_mem_access_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        valid, mem_read, mem_write, indirect, byte_op, sign_ext;
    logic        hold_in, mem_resp;
    logic [15:0] addr, wdata, mem_rdata;
    logic        mem_read_o, mem_write_o, stall;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_address, mem_wdata, load_data;

    logic        v32, rd32, wr32, ind32, byte32, sx32, hold32, resp32;
    logic [15:0] addr32;
    logic [31:0] wdata32, rdata32;
    logic        rd_o32, wr_o32, stall32;
    logic [3:0]  mask32;
    logic [15:0] maddr32;
    logic [31:0] mwdata32, load32;

    mem_access_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .valid(valid), .mem_read(mem_read),
        .mem_write(mem_write), .indirect(indirect), .byte_op(byte_op),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .hold_in(hold_in),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .load_data(load_data), .stall(stall)
    );

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut32 (
        .clk(clk), .reset(reset), .valid(v32), .mem_read(rd32),
        .mem_write(wr32), .indirect(ind32), .byte_op(byte32),
        .sign_ext(sx32), .addr(addr32), .wdata(wdata32), .hold_in(hold32),
        .mem_resp(resp32), .mem_rdata(rdata32), .mem_read_o(rd_o32),
        .mem_write_o(wr_o32), .mem_wmask(mask32),
        .mem_address(maddr32), .mem_wdata(mwdata32),
        .load_data(load32), .stall(stall32)
    );

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;
    int phase = 0;
    logic exp_rd, exp_wr, exp_stall;
    logic [1:0] exp_mask;
    logic [15:0] exp_addr, exp_wdata, model_load;
    int stall_cnt;
    logic [15:0] cap_ptr, cap_addr, cap_wdata;
    logic [1:0] cap_mask;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("rd_o", 32'(mem_read_o), 32'(exp_rd));
            chk("wr_o", 32'(mem_write_o), 32'(exp_wr));
            chk("wmask", 32'(mem_wmask), 32'(exp_mask));
            chk("address", 32'(mem_address), 32'(exp_addr));
            chk("wdata_o", 32'(mem_wdata), 32'(exp_wdata));
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("load_data", 32'(load_data), 32'(model_load));
            if (stall) stall_cnt++;
            if (phase == 1) cap_ptr = mem_address;
            if (phase == 2) begin
                cap_addr  = mem_address;
                cap_mask  = mem_wmask;
                cap_wdata = mem_wdata;
            end
        end
    end

    task automatic exp_quiet(input logic st);
        phase     = 0;
        exp_rd    = 1'b0;
        exp_wr    = 1'b0;
        exp_mask  = 2'b00;
        exp_addr  = 16'h0;
        exp_wdata = 16'h0;
        exp_stall = st;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            valid     = k[0];
            mem_read  = ~k[0];
            mem_write = 1'b0;
            indirect  = 1'b0;
            hold_in   = 1'b0;
            mem_resp  = 1'b1;
            mem_rdata = 16'($urandom);
            exp_quiet(1'b0);
        end
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic ind,
                          input logic bop, input logic sx,
                          input logic [15:0] a, input logic [15:0] wd,
                          input int pw, input int dw,
                          input logic [15:0] prd, input logic [15:0] drd,
                          input int hold);
        logic [15:0] eff;
        logic [15:0] nload;
        logic [7:0]  b;
        logic        st;
        st = wr & ~rd;
        @(negedge clk);
        valid = 1'b1; mem_read = rd; mem_write = wr; indirect = ind;
        byte_op = bop; sign_ext = sx; addr = a; wdata = wd;
        hold_in = 1'b0; mem_resp = 1'b1; mem_rdata = 16'($urandom);
        exp_quiet(1'b1);
        stall_cnt = 0;
        eff = a;
        if (ind) begin
            for (int k = 0; k <= pw; k++) begin
                @(negedge clk);
                addr = ~a; wdata = ~wd;
                exp_quiet(1'b1);
                phase    = 1;
                exp_rd   = 1'b1;
                exp_addr = a & 16'hFFFE;
                mem_resp  = (k == pw);
                mem_rdata = (k == pw) ? prd : 16'($urandom);
            end
            eff = prd;
        end
        for (int k = 0; k <= dw; k++) begin
            @(negedge clk);
            addr = ~a; wdata = ~wd;
            exp_quiet(1'b1);
            phase     = 2;
            exp_rd    = rd;
            exp_wr    = st;
            exp_addr  = bop ? eff : (eff & 16'hFFFE);
            exp_mask  = !st ? 2'b00 : (!bop ? 2'b11 : (eff[0] ? 2'b10 : 2'b01));
            exp_wdata = !st ? 16'h0 : (bop ? {wd[7:0], wd[7:0]} : wd);
            mem_resp  = (k == dw);
            mem_rdata = (k == dw) ? drd : 16'($urandom);
        end
        b = eff[0] ? drd[15:8] : drd[7:0];
        nload = !bop ? drd : (sx ? {{8{b[7]}}, b} : {8'h00, b});
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            exp_quiet(1'b0);
            if (rd) model_load = nload;
            hold_in = (k < hold);
            valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; indirect = 1'b0;
            addr = 16'h5555; mem_resp = 1'b1; mem_rdata = 16'($urandom);
        end
    endtask

    initial begin
        reset = 1'b1;
        valid = 0; mem_read = 0; mem_write = 0; indirect = 0; byte_op = 0;
        sign_ext = 0; addr = 0; wdata = 0; hold_in = 0; mem_resp = 0;
        mem_rdata = 0;
        v32 = 0; rd32 = 0; wr32 = 0; ind32 = 0; byte32 = 0; sx32 = 0;
        hold32 = 0; resp32 = 0; addr32 = 0; wdata32 = 0; rdata32 = 0;
        model_load = 16'h0; stall_cnt = 0;
        exp_quiet(1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        run_op(1, 0, 0, 1, 1, 16'h3001, 16'h0, 0, 2, 16'h0, 16'h80FF, 0);
        #3;
        chk("ldb_s_load", 32'(load_data), 32'h0000FF80);
        chk("ldb_s_addr", 32'(cap_addr), 32'h00003001);
        chk("ldb_s_stall", 32'(stall_cnt), 32'd4);
        run_op(1, 0, 0, 1, 0, 16'h3001, 16'h0, 0, 2, 16'h0, 16'h80FF, 0);
        #3;
        chk("ldb_z_load", 32'(load_data), 32'h00000080);
        run_op(0, 1, 0, 1, 0, 16'h4000, 16'h12AB, 0, 1, 16'h0, 16'h0, 0);
        #3;
        chk("stb0_wdata", 32'(cap_wdata), 32'h0000ABAB);
        chk("stb0_mask", 32'(cap_mask), 32'h1);
        run_op(0, 1, 0, 1, 0, 16'h4001, 16'h12AB, 0, 0, 16'h0, 16'h0, 0);
        #3;
        chk("stb1_mask", 32'(cap_mask), 32'h2);
        run_op(1, 0, 1, 0, 0, 16'h1003, 16'h0, 1, 0, 16'h2005, 16'hBEEF, 0);
        #3;
        chk("ldi_ptr", 32'(cap_ptr), 32'h00001002);
        chk("ldi_addr", 32'(cap_addr), 32'h00002004);
        chk("ldi_load", 32'(load_data), 32'h0000BEEF);
        chk("ldi_stall", 32'(stall_cnt), 32'd4);
        run_op(0, 1, 0, 0, 0, 16'h0106, 16'h1234, 0, 0, 16'h0, 16'h0, 3);
        run_op(0, 1, 1, 0, 0, 16'h2000, 16'hCAFE, 0, 0, 16'h3011, 16'h0, 0);
        #3;
        chk("sti_addr", 32'(cap_addr), 32'h00003010);
        chk("sti_mask", 32'(cap_mask), 32'h3);
        run_op(1, 1, 0, 1, 0, 16'h5003, 16'h7777, 0, 1, 16'h0, 16'h9A00, 0);
        #3;
        chk("rw_mask", 32'(cap_mask), 32'h0);
        chk("rw_load", 32'(load_data), 32'h0000009A);
        run_op(1, 0, 0, 1, 1, 16'h6000, 16'h0, 0, 0, 16'h0, 16'h117F, 2);
        run_op(1, 0, 0, 0, 0, 16'h0A0B, 16'h0, 0, 1, 16'h0, 16'h4321, 0);
        idle(1);

        @(negedge clk);
        valid = 0; exp_quiet(1'b0);
        v32 = 1; rd32 = 1; addr32 = 16'h0106; rdata32 = 32'h0;
        #3;
        chk("w32_acc_stall", 32'(stall32), 32'h1);
        chk("w32_acc_rd", 32'(rd_o32), 32'h0);
        @(negedge clk);
        v32 = 0; rd32 = 0; addr32 = 16'h0; resp32 = 1; rdata32 = 32'hCAFEF00D;
        #3;
        chk("w32_rd", 32'(rd_o32), 32'h1);
        chk("w32_addr", 32'(maddr32), 32'h00000104);
        chk("w32_mask", 32'(mask32), 32'h0);
        @(negedge clk);
        resp32 = 0; rdata32 = 32'h0;
        #3;
        chk("w32_load", load32, 32'hCAFEF00D);
        chk("w32_done_stall", 32'(stall32), 32'h0);
        chk("w32_done_rd", 32'(rd_o32), 32'h0);
        @(negedge clk);
        v32 = 1; wr32 = 1; byte32 = 1; addr32 = 16'h0103; wdata32 = 32'h1234565A;
        @(negedge clk);
        v32 = 0; wr32 = 0; byte32 = 0; resp32 = 1;
        #3;
        chk("b32_wr", 32'(wr_o32), 32'h1);
        chk("b32_mask", 32'(mask32), 32'h8);
        chk("b32_wdata", mwdata32, 32'h5A5A5A5A);
        chk("b32_addr", 32'(maddr32), 32'h00000103);
        @(negedge clk);
        resp32 = 0;
        #3;
        chk("b32_load_kept", load32, 32'hCAFEF00D);
        chk("b32_done_wr", 32'(wr_o32), 32'h0);

        @(negedge clk);
        valid = 1; mem_read = 1; mem_write = 0; indirect = 0; byte_op = 0;
        addr = 16'h0200; mem_resp = 0; hold_in = 0;
        exp_quiet(1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            valid = 0; mem_resp = 0;
            reset = (k == 2);
            exp_quiet(1'b1);
            phase = 2; exp_rd = 1'b1; exp_addr = 16'h0200;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            reset = 0; mem_resp = 1; mem_rdata = 16'h7777;
            exp_quiet(1'b0);
            model_load = 16'h0;
        end
        #3;
        chk("rst_load", 32'(load_data), 32'h0);
        idle(2);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage access controller for the pipelined LC-3b core. It supersedes the purely combinational memory-stage path with a registered, state-machine-driven port. It supports configurable data width with byte-lane steering, signed or zero byte loads, and two-access indirect operations (LDI/STI). It also holds every memory request stable until `mem_resp` and generates the stage `stall`.

## Interface
Parameters:
- `DATA_WIDTH`, 16: memory word width. Must be a multiple of 8 and ≥16. `LANES = DATA_WIDTH/8`, `LB = log2(LANES)`.
- `ADDR_WIDTH`, 16: byte-address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `valid` in 1: an instruction occupies the memory stage.
- `mem_read` in 1: instruction loads.
- `mem_write` in 1: instruction stores.
- `indirect` in 1: address is a pointer location (LDI/STI).
- `byte_op` in 1: byte access.
- `sign_ext` in 1: sign-extend a byte load (0 = zero-extend).
- `addr` in ADDR_WIDTH: effective byte address.
- `wdata` in DATA_WIDTH: store data; bits [7:0] only for byte stores.
- `hold_in` in 1: another stage freezes the pipeline.
- `mem_resp` in 1: memory completes the current request.
- `mem_rdata` in DATA_WIDTH: memory read data.
- `mem_read_o` out 1: memory read strobe.
- `mem_write_o` out 1: memory write strobe.
- `mem_wmask` out LANES: byte-lane write enables.
- `mem_address` out ADDR_WIDTH: memory address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `load_data` out DATA_WIDTH: extended load result, registered.
- `stall` out 1: freeze the pipeline.

## Operation
- States: IDLE, PTR, DATA, DONE. Encoding is free.
- IDLE:
  - If `valid & (mem_read | mem_write)`: latch `addr`, `wdata`, op flags; go to PTR if `indirect`, else DATA.
  - If both `mem_read` and `mem_write` are set, treat as a read and suppress the write.
  - Otherwise stay in IDLE.
- PTR:
  - Drive `mem_read_o`=1 at the latched address with its low LB bits cleared.
  - On `mem_resp`: replace the latched address with `mem_rdata[ADDR_WIDTH-1:0]`; go to DATA.
- DATA:
  - Drive `mem_read_o` or `mem_write_o` per the latched op.
  - Address: word op clears the low LB bits; byte op uses the address as-is.
  - `mem_wmask`: word store drives all ones; byte store drives one-hot lane `addr[LB-1:0]`; reads drive 0.
  - `mem_wdata`: byte store replicates `wdata[7:0]` into every lane; word store passes `wdata` through.
  - On `mem_resp`:
    - Load: `load_data` ← word, or the selected lane extended per `sign_ext`.
    - Store: `load_data` unchanged.
    - Go to DONE.
- DONE: go to IDLE when `hold_in`=0; stay in DONE while `hold_in`=1 (no new request issued).
- `stall` (combinational from state and inputs):
  - IDLE: `valid & (mem_read | mem_write)`.
  - PTR, DATA: 1.
  - DONE: 0.
- Memory outputs are decoded from the registered state and latched fields only. Outside PTR/DATA all strobes, `mem_wmask`, `mem_address` and `mem_wdata` are 0.
- `mem_resp` outside PTR/DATA is ignored.

## Timing
- Reset: state = IDLE; all latches and `load_data` = 0; all memory outputs 0. `stall` then follows the IDLE rule.
- Reset mid-access: the operation is aborted. Strobes are 0 in the cycle after the reset edge, and the late `mem_resp` is ignored.
- Direct access, resp in first DATA cycle:
  - cycle 0: IDLE accepts, `stall`=1.
  - cycle 1: DATA request, `stall`=1.
  - cycle 2: DONE, `stall`=0, `load_data` valid.
- Indirect access minimum: 4 cycles, with `stall`=1 for 3 cycles.
- Each extra cycle without `mem_resp` extends the current state by one. The request stays bit-stable throughout.
- `load_data` stays valid from DONE until the next load completes.
- Back-to-back memory instructions: the next one is accepted in the IDLE cycle after DONE. There is no dead cycle beyond DONE.

## Test plan
- Signed LDB, DATA_WIDTH=16: `addr`=0x3001, `sign_ext`=1, rdata 0x80FF, resp after 2 wait cycles -> `mem_address`=0x3001, `load_data`=0xFF80, `stall` high for 4 cycles. Repeat with `sign_ext`=0 -> 0x0080.
- STB: `addr`=0x4000, `wdata`=0x12AB -> `mem_wdata`=0xABAB, `mem_wmask`=2'b01, `mem_write_o` held until resp. Repeat at 0x4001 -> `mem_wmask`=2'b10.
- LDI: `addr`=0x1003, pointer rdata 0x2005, data rdata 0xBEEF -> first read at 0x1002, second read at 0x2004, `load_data`=0xBEEF.
- DATA_WIDTH=32 word load: `addr`=0x0106 -> `mem_address`=0x0104, `mem_wmask`=0, 32-bit `load_data` equals rdata.
- `hold_in`=1 for 3 cycles in DONE -> `stall`=0, no strobes, state stays DONE; the next load is accepted only after `hold_in` falls.
- Reset asserted while in DATA awaiting resp -> strobes 0 next cycle; late `mem_resp` ignored; `load_data`=0.
